cpu_halt_monitor: RTL and testbench
===================================

# cpu_halt_monitor

Watches the single-cycle MIPS CPU's per-cycle fetch stream (PC, instruction, `$v0`) and decides when the program has finished. It sits directly downstream of `SINGLE_CYCLE_CPU` in the simulation and FPGA top levels, and replaces fixed-delay `$finish` timing. End conditions are an exit syscall, a self-loop, or a cycle-budget timeout. It also reports cycle and instruction counts plus the final PC.

## Interface
- `TIMEOUT_CYCLES`, default 300: RUN-cycle budget before forced halt (300 = 6000 ns at 20 ns clock).
- `LOOP_LIMIT`, default 4: consecutive identical-PC samples that count as a self-loop; legal range 2..255.
- `EXIT_CODE`, default 10: `$v0` value that, with `syscall`, means program exit.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: **one clock; reset is asynchronous and active-high**.
- `start` in 1: level; IDLE→RUN when high.
- `valid` in 1: an instruction retires this cycle; `pc`/`instr`/`v0` are meaningful.
- `pc` in 32: byte address of the retiring instruction.
- `instr` in 32: retiring instruction word.
- `v0` in 32: current contents of register `$2`.
- `running` out 1: state == RUN.
- `done` out 1: state == HALTED; sticky.
- `halt_cause` out 2: 0 none, 1 syscall exit, 2 self-loop, 3 timeout.
- `cycle_count` out 32: RUN cycles elapsed.
- `instr_count` out 32: valid retirements counted.
- `final_pc` out 32: `pc` captured on the halting sample.

## Operation
- States:
  - IDLE: IDLE→RUN when `start` is high; all inputs other than `start` ignored.
  - RUN: on each edge, `cycle_count`+1.
    - If `valid`: `instr_count`+1 and evaluate the halt checks.
    - If any check fires → HALTED.
  - HALTED: terminal until `reset`; inputs ignored, outputs frozen.
- Syscall check: `valid && instr == 32'h0000000C && v0 == EXIT_CODE`. Any other `$v0` with `syscall` is an ordinary instruction.
- Self-loop check:
  - Registered `prev_pc` and 8-bit `same_cnt`.
  - When `valid` and `pc == prev_pc`, `same_cnt`+1; otherwise `same_cnt` = 1 and `prev_pc` = `pc`.
  - Fires when the updated `same_cnt == LOOP_LIMIT`.
  - The first valid sample after reset always loads `prev_pc`; it never counts as a match.
- Timeout check: fires on the edge where the incremented `cycle_count` equals `TIMEOUT_CYCLES`, regardless of `valid`.
- Simultaneous checks use fixed priority: syscall > self-loop > timeout. `halt_cause` records only the winner.
- Saturation: `cycle_count` and `instr_count` saturate at 32'hFFFF_FFFF and never wrap.
- `final_pc`:
  - Loaded with `pc` on the halting edge.
  - For a timeout with `valid` low, it holds the last valid `pc` seen (0 if none).
- `valid` low in RUN: only cycle and timeout logic advance; `same_cnt` and `prev_pc` hold.

## Timing
- All state is registered; outputs come directly from registers, with no combinational input→output path.
- Reset values: state IDLE, `running` 0, `done` 0, `halt_cause` 0, `cycle_count` 0, `instr_count` 0, `final_pc` 0. Internal reset values: `prev_pc` 0, `same_cnt` 0.
- Reset asserted mid-RUN or in HALTED returns to IDLE immediately (asynchronous); counts are lost.
- `start` sampled high at edge N → `running` high after edge N. The first counted cycle is edge N+1.
- Halt detected at edge M: `done`, `halt_cause`, `final_pc` and the final counts are all valid after edge M, in the same cycle. `running` drops at the same time.
- Counts include the halting cycle and the halting instruction.

## Structure
- Shared package `cpu_sim_pkg`:
  - `halt_cause_t` enum (NONE, SYSCALL, LOOP, TIMEOUT).
  - `mon_state_t` enum (IDLE, RUN, HALTED).
  - Constant `SYSCALL_WORD = 32'h0000000C`.
  - Constant `V0_REG = 2`.
- One sub-module `pc_loop_detector` holds `prev_pc`/`same_cnt` and outputs the loop-hit pulse. The top level holds the FSM, counters and priority encoding.

## Test plan
- Syscall exit: `start` high; 5 valid instrs at PCs 0,4,8,12,16; last is `0000000C` with `v0=10`. Expect `done`=1, cause 1, `instr_count`=5, `cycle_count`=5, `final_pc`=16.
- Syscall with `v0=1` at PC 8, then `0x08000003` (`j 12`) repeating at PC 12. Expect no halt at 8; expect cause 2 when the 4th consecutive PC-12 sample lands, `final_pc`=12.
- Timeout: `valid` stays low, or PCs keep incrementing. Expect `done` after exactly 300 RUN cycles, cause 3, `cycle_count`=300.
- Priority: the 4th repeat of PC 20 is a syscall with `v0=10`. Expect cause 1, not 2.
- `valid` gaps: PC 12 valid, invalid, valid, invalid, valid, valid. Expect loop hit on the 4th valid sample, `cycle_count`=6, `instr_count` increments only on valid cycles.
- Async reset mid-RUN after 50 cycles, then again in HALTED. Expect all outputs 0 and state IDLE before the next edge. A new `start` recounts from 0.

Source files
------------

// File: rtl/cpu_sim_pkg.sv
// Shared types and constants for the single-cycle CPU simulation environment.
package cpu_sim_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned SAME_CNT_W = 8;

    localparam logic [WORD_W-1:0] SYSCALL_WORD = 32'h0000_000C;
    localparam int unsigned       V0_REG       = 2;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        SYSCALL = 2'd1,
        LOOP    = 2'd2,
        TIMEOUT = 2'd3
    } halt_cause_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } mon_state_t;

endpackage

// File: rtl/cpu_halt_monitor_if.sv
// Retirement stream from the CPU into the halt monitor, plus the monitor's status.
interface cpu_halt_monitor_if;
    import cpu_sim_pkg::*;

    logic              start;
    logic              valid;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] v0;

    logic              running;
    logic              done;
    halt_cause_t       halt_cause;
    logic [WORD_W-1:0] cycle_count;
    logic [WORD_W-1:0] instr_count;
    logic [WORD_W-1:0] final_pc;

    modport master (
        output start, valid, pc, instr, v0,
        input  running, done, halt_cause, cycle_count, instr_count, final_pc
    );

    modport slave (
        input  start, valid, pc, instr, v0,
        output running, done, halt_cause, cycle_count, instr_count, final_pc
    );

endinterface

// File: rtl/pc_loop_detector.sv
// Tracks the run length of identical retiring PCs and flags a self-loop.
module pc_loop_detector
    import cpu_sim_pkg::*;
#(
    parameter int unsigned LOOP_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [WORD_W-1:0] pc,
    output logic              loop_hit_c,
    output logic [WORD_W-1:0] prev_pc
);

    localparam logic [SAME_CNT_W-1:0] SAME_MAX = '1;

    logic [SAME_CNT_W-1:0] same_cnt;
    logic [SAME_CNT_W-1:0] same_nxt_c;
    logic                  match_c;

    // same_cnt == 0 marks "no sample yet", so a first pc of 0 never matches.
    always_comb begin
        match_c    = 1'b0;
        same_nxt_c = SAME_CNT_W'(1);
        loop_hit_c = 1'b0;
        match_c    = (same_cnt != '0) && (pc == prev_pc);
        if (match_c) begin
            same_nxt_c = (same_cnt == SAME_MAX) ? same_cnt : same_cnt + SAME_CNT_W'(1);
        end
        loop_hit_c = en && (same_nxt_c == SAME_CNT_W'(LOOP_LIMIT));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            same_cnt <= '0;
            prev_pc  <= '0;
        end else if (en) begin
            same_cnt <= same_nxt_c;
            if (!match_c) begin
                prev_pc <= pc;
            end
        end
    end

endmodule

// File: rtl/cpu_halt_monitor.sv
// Decides when the simulated program has finished (exit syscall, self-loop or
// cycle budget) and reports cycle/instruction counts and the final PC.
module cpu_halt_monitor
    import cpu_sim_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYCLES = 300,
    parameter int unsigned       LOOP_LIMIT     = 4,
    parameter logic [WORD_W-1:0] EXIT_CODE      = 32'd10
) (
    input  logic              clk,
    input  logic              reset,
    cpu_halt_monitor_if.slave bus
);

    localparam logic [WORD_W-1:0] CNT_MAX = '1;

    mon_state_t        state;
    logic              running_q;
    logic              done_q;
    halt_cause_t       cause_q;
    logic [WORD_W-1:0] cycle_q;
    logic [WORD_W-1:0] instr_q;
    logic [WORD_W-1:0] final_pc_q;

    logic              loop_en_c;
    logic              loop_hit_c;
    logic              sys_hit_c;
    logic              timeout_hit_c;
    logic [WORD_W-1:0] prev_pc;
    logic [WORD_W-1:0] cycle_inc_c;
    logic [WORD_W-1:0] instr_inc_c;
    halt_cause_t       cause_c;

    assign loop_en_c = (state == RUN) && bus.valid;

    pc_loop_detector #(
        .LOOP_LIMIT (LOOP_LIMIT)
    ) u_loop (
        .clk        (clk),
        .reset      (reset),
        .en         (loop_en_c),
        .pc         (bus.pc),
        .loop_hit_c (loop_hit_c),
        .prev_pc    (prev_pc)
    );

    // Saturating increments and prioritised halt decision for this edge.
    always_comb begin
        cycle_inc_c   = '0;
        instr_inc_c   = '0;
        sys_hit_c     = 1'b0;
        timeout_hit_c = 1'b0;
        cause_c       = NONE;

        cycle_inc_c   = (cycle_q == CNT_MAX) ? cycle_q : cycle_q + WORD_W'(1);
        instr_inc_c   = (instr_q == CNT_MAX) ? instr_q : instr_q + WORD_W'(1);
        sys_hit_c     = loop_en_c && (bus.instr == SYSCALL_WORD) && (bus.v0 == EXIT_CODE);
        timeout_hit_c = (state == RUN) && (cycle_inc_c == WORD_W'(TIMEOUT_CYCLES));

        if (sys_hit_c) begin
            cause_c = SYSCALL;
        end else if (loop_hit_c) begin
            cause_c = LOOP;
        end else if (timeout_hit_c) begin
            cause_c = TIMEOUT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            cause_q    <= NONE;
            cycle_q    <= '0;
            instr_q    <= '0;
            final_pc_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state     <= RUN;
                        running_q <= 1'b1;
                    end
                end
                RUN: begin
                    cycle_q <= cycle_inc_c;
                    if (bus.valid) begin
                        instr_q <= instr_inc_c;
                    end
                    // prev_pc still holds the last valid pc when valid is low.
                    if (cause_c != NONE) begin
                        state      <= HALTED;
                        running_q  <= 1'b0;
                        done_q     <= 1'b1;
                        cause_q    <= cause_c;
                        final_pc_q <= bus.valid ? bus.pc : prev_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.running     = running_q;
    assign bus.done        = done_q;
    assign bus.halt_cause  = cause_q;
    assign bus.cycle_count = cycle_q;
    assign bus.instr_count = instr_q;
    assign bus.final_pc    = final_pc_q;

endmodule

// File: tb/tb_cpu_halt_monitor.sv
// Directed and randomized bench for cpu_halt_monitor against a trace-level model.
module tb_cpu_halt_monitor;

    localparam int unsigned TIMEOUT = 300;
    localparam int unsigned LIMIT   = 4;
    localparam int unsigned EXIT    = 10;
    localparam logic [31:0] SYS     = 32'h0000_000C;
    localparam logic [31:0] JMP12   = 32'h0800_0003;

    logic clk = 1'b0;
    logic reset;

    cpu_halt_monitor_if bus ();

    cpu_halt_monitor #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .LOOP_LIMIT     (LIMIT),
        .EXIT_CODE      (EXIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: 0 idle, 1 running, 2 halted; hist keeps the last LIMIT valid PCs.
    int          m_state;
    int          m_cause;
    logic [31:0] m_cyc, m_ins, m_last, m_final;
    logic [31:0] hist[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".running"}, 32'(bus.running), 32'(m_state == 1));
        chk({tag, ".done"},    32'(bus.done),    32'(m_state == 2));
        chk({tag, ".cause"},   32'(bus.halt_cause), 32'(m_cause));
        chk({tag, ".cycles"},  bus.cycle_count, m_cyc);
        chk({tag, ".instrs"},  bus.instr_count, m_ins);
        chk({tag, ".final_pc"}, bus.final_pc,   m_final);
    endtask

    task automatic model_reset();
        m_state = 0;
        m_cause = 0;
        m_cyc   = '0;
        m_ins   = '0;
        m_last  = '0;
        m_final = '0;
        hist.delete();
    endtask

    task automatic model_edge(input logic s, input logic v, input logic [31:0] p,
                              input logic [31:0] i, input logic [31:0] r);
        bit hs, hl, ht;
        int run;
        hs = 0; hl = 0; ht = 0; run = 0;
        if (m_state == 0) begin
            if (s) m_state = 1;
        end else if (m_state == 1) begin
            if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
            if (v) begin
                if (m_ins != 32'hFFFF_FFFF) m_ins = m_ins + 1;
                m_last = p;
                hist.push_back(p);
                if (hist.size() > int'(LIMIT)) void'(hist.pop_front());
                for (int k = hist.size() - 1; k >= 0; k--) begin
                    if (hist[k] != p) break;
                    run++;
                end
                hs = (i == SYS) && (r == EXIT);
                hl = (run == int'(LIMIT));
            end
            ht = (m_cyc == TIMEOUT);
            if (hs || hl || ht) begin
                m_state = 2;
                m_cause = hs ? 1 : (hl ? 2 : 3);
                m_final = m_last;
            end
        end
    endtask

    // One clock: drive, let the edge happen, update model, sample 1 time unit later.
    task automatic step(input logic s, input logic v, input logic [31:0] p,
                        input logic [31:0] i, input logic [31:0] r, input string tag);
        bus.start = s; bus.valid = v; bus.pc = p; bus.instr = i; bus.v0 = r;
        @(posedge clk);
        model_edge(s, v, p, i, r);
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset(input string tag);
        reset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        reset = 1'b0;
        #1;
    endtask

    function automatic logic [31:0] plain_instr();
        return $urandom | 32'h8000_0000;
    endfunction

    initial begin
        logic        v;
        logic [31:0] p, i, r;
        int          npc;

        reset = 1'b1;
        bus.start = 0; bus.valid = 0; bus.pc = 0; bus.instr = 0; bus.v0 = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b0;

        // Idle ignores everything except start.
        for (int c = 0; c < 4; c++) step(0, 1, 32'h40, SYS, EXIT, "idle");

        // Exit syscall on the fifth instruction.
        step(1, 0, 0, 0, 0, "sys.start");
        for (int c = 0; c < 5; c++)
            step(1, 1, 32'(4 * c), (c == 4) ? SYS : plain_instr(), EXIT, "sys");
        chk("sys.cause_const", 32'(bus.halt_cause), 1);
        chk("sys.instr_const", bus.instr_count, 5);
        chk("sys.cycle_const", bus.cycle_count, 5);
        chk("sys.pc_const",    bus.final_pc, 16);
        for (int c = 0; c < 3; c++) step($urandom_range(0, 1), 1, $urandom, SYS, EXIT, "halted.frozen");

        // Non-exit syscall, then j 12 spinning at PC 12.
        async_reset("loop.rst");
        step(1, 0, 0, 0, 0, "loop.start");
        step(1, 1, 0, plain_instr(), 1, "loop");
        step(1, 1, 4, plain_instr(), 1, "loop");
        step(1, 1, 8, SYS, 1, "loop.sys_v0_1");
        for (int c = 0; c < 4; c++) step(1, 1, 12, JMP12, 1, "loop");
        chk("loop.cause_const", 32'(bus.halt_cause), 2);
        chk("loop.pc_const",    bus.final_pc, 12);

        // Timeout with valid held low: final_pc stays 0.
        async_reset("to.rst");
        step(1, 0, 0, 0, 0, "to.start");
        for (int c = 0; c < int'(TIMEOUT); c++) step(0, 0, $urandom, SYS, EXIT, "to.idle_bus");
        chk("to.cycle_const", bus.cycle_count, TIMEOUT);
        chk("to.cause_const", 32'(bus.halt_cause), 3);

        // Timeout with incrementing PCs and gaps: final_pc is the last valid pc.
        async_reset("to2.rst");
        step(1, 0, 0, 0, 0, "to2.start");
        for (int c = 0; c < int'(TIMEOUT); c++)
            step(0, 1'($urandom_range(0, 1)), 32'(4 * c), plain_instr(), EXIT, "to2");
        chk("to2.cycle_const", bus.cycle_count, TIMEOUT);

        // Syscall exit outranks the simultaneous loop hit.
        async_reset("prio.rst");
        step(1, 0, 0, 0, 0, "prio.start");
        for (int c = 0; c < 4; c++) step(1, 1, 20, (c == 3) ? SYS : plain_instr(), EXIT, "prio");
        chk("prio.cause_const", 32'(bus.halt_cause), 1);

        // Invalid cycles neither break nor extend the run of PC 12.
        async_reset("gap.rst");
        step(1, 0, 0, 0, 0, "gap.start");
        step(1, 1, 12, JMP12, 0, "gap");
        step(1, 0, 32'hDEAD, JMP12, 0, "gap");
        step(1, 1, 12, JMP12, 0, "gap");
        step(1, 0, 32'hBEEF, JMP12, 0, "gap");
        step(1, 1, 12, JMP12, 0, "gap");
        step(1, 1, 12, JMP12, 0, "gap");
        chk("gap.cycle_const", bus.cycle_count, 6);
        chk("gap.instr_const", bus.instr_count, 4);
        chk("gap.cause_const", 32'(bus.halt_cause), 2);

        // First sample at PC 0 must not pair with the reset value of the tracker.
        async_reset("pc0.rst");
        step(1, 0, 0, 0, 0, "pc0.start");
        for (int c = 0; c < 4; c++) step(1, 1, 0, plain_instr(), 0, "pc0");

        // Async reset mid-run, idle hold, then a fresh recount.
        async_reset("mid.rst0");
        step(1, 0, 0, 0, 0, "mid.start");
        for (int c = 0; c < 50; c++) step(0, 1, 32'(4 * c), plain_instr(), EXIT, "mid.run");
        async_reset("mid.rst");
        for (int c = 0; c < 3; c++) step(0, 1, 32'h100, SYS, EXIT, "mid.idle");
        step(1, 0, 0, 0, 0, "mid.restart");
        for (int c = 0; c < 3; c++) step(0, 1, 32'(4 * c), plain_instr(), EXIT, "mid.recount");
        chk("mid.cycle_const", bus.cycle_count, 3);
        step(0, 1, 12, SYS, EXIT, "mid.exit");
        async_reset("halted.rst");

        // Randomized streams over a small PC pool.
        for (int run = 0; run < 16; run++) begin
            async_reset("rnd.rst");
            step(1, 0, 0, 0, 0, "rnd.start");
            npc = $urandom_range(1, 6);
            for (int c = 0; c < int'(TIMEOUT) + 10 && m_state != 2; c++) begin
                v = ($urandom_range(0, 3) != 0);
                p = 32'(4 * $urandom_range(0, npc - 1));
                i = ($urandom_range(0, 9) == 0) ? SYS : plain_instr();
                r = ($urandom_range(0, 1) != 0) ? 32'(EXIT) : 32'($urandom_range(0, 20));
                step(1'($urandom_range(0, 1)), v, p, i, r, "rnd");
            end
            chk("rnd.halted", 32'(bus.done), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
